pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised elastic pipeline register for the pipelined processor. It replaces fixed inter-stage latches (EX/MEM, MEM/WB style) with a chain of NUM_STAGES skid-buffered stages that carry a control field and a data payload under a valid/ready handshake. It supports stall by backpressure and a synchronous flush. Bubbles always present an all-zero control field, so a squashed slot can never assert RegWrite or MemToReg downstream.

## Interface
- DATA_WIDTH, 64: payload width (e.g. ALU result concatenated with memory data and write-register number).
- CTRL_WIDTH, 2: control-bit width. Forced to zero on any invalid output slot.
- NUM_STAGES, 1: number of chained elastic stages. Legal range 1..4.
- CNT_WIDTH, $clog2(2*NUM_STAGES+1): derived, not overridable; width of occupancy.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block accepts an entry this cycle.
- in_ctrl  in  CTRL_WIDTH  upstream control bits.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_WIDTH  control bits of the head entry; 0 when out_valid=0.
- out_data  out  DATA_WIDTH  payload of the head entry.
- occupancy  out  CNT_WIDTH  number of valid entries held, 0..2*NUM_STAGES.

## Operation
- Each stage holds a main register and a skid register, each with its own valid bit, ctrl and data. Stage output comes from main. A stage's upstream ready equals its own skid-empty flag (registered).
- Transfers occur only on a cycle where valid=1 and ready=1, at both the block boundary and between stages.
- Per stage, with the downstream handshake taken first:
  - Main empty, or main emptied this cycle: main loads from skid if skid is valid, otherwise from the incoming entry. Skid clears once it has been drained into main.
  - Main held (valid and not accepted) with an incoming transfer: the entry goes to skid. This can only happen when skid is empty, because ready was 1.
- Ordering is strict FIFO. No entry is dropped or duplicated outside flush.
- flush=1: all main and skid valid bits clear at the edge. Any transfer in the same cycle is discarded. in_ready is forced to 0 and out_valid to 0 combinationally while flush=1. Data and ctrl registers keep their values, but out_ctrl still reads 0 through gating.
- rst=1: all valid bits, ctrl and data registers are 0. rst takes precedence over flush and handshakes.
- out_ctrl = main_ctrl of the last stage AND out_valid (bitwise gating). out_data is not gated.
- occupancy is the registered count of all set valid bits. After a flush or reset it reads 0 on the next cycle.

## Timing
- Reset values: in_ready=1 (first cycle after rst deasserts), out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- Latency: NUM_STAGES cycles from an accepted input to out_valid, with no backpressure.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- No combinational path from out_ready to in_ready, nor from in_valid to out_valid. The only combinational paths are from flush, and from the valid bits to out_ctrl.
- Full: occupancy=2*NUM_STAGES implies in_ready=0. Once out_ready is held at 0, in_ready falls within NUM_STAGES+1 cycles, and only after the first-stage skid fills.
- A simultaneous push and pop when full is impossible, because in_ready=0. A simultaneous push and pop at any other occupancy leaves occupancy unchanged.
- After rst deasserts mid-stream, the block behaves as freshly empty. Entries held before reset are lost.

## Test plan
- NUM_STAGES=1: push ctrl=2'b11, data=64'hA5 with out_ready=1. Expect out_valid=1, out_ctrl=2'b11, out_data=64'hA5 one cycle later, and occupancy returning to 0.
- NUM_STAGES=3: stream 16 consecutive entries (data=0..15, out_ready=1). Expect 16 outputs in order, starting 3 cycles after the first push, with no gap cycles.
- NUM_STAGES=2: out_ready=0 and in_valid held at 1. Expect exactly 4 entries accepted, in_ready=0, occupancy=4. Then raise out_ready and expect the 4 entries out in order, followed by the next inputs.
- Flush with occupancy=3 while in_valid=1: in_ready=0 and out_valid=0 during the flush cycle. The next cycle shows occupancy=0, out_ctrl=0, and the flushed entries never appear.
- Assert rst for 1 cycle while full. The next cycle shows out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Random valid/ready (10k cycles, NUM_STAGES 1..4) against a scoreboard queue. Expect no loss, duplication or reordering, and out_ctrl==0 on every cycle with out_valid=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic replacement for a fixed inter-stage pipeline latch. A chain of
// NUM_STAGES skid-buffered stages carries a control field and a payload
// under a valid/ready handshake. Backpressure stalls the chain, flush kills
// every in-flight entry, and an invalid output slot always shows an all-zero
// control field so a bubble can never assert a write-enable downstream.
//
// Parameters
//   DATA_WIDTH  payload width
//   CTRL_WIDTH  control field width (gated to zero on invalid slots)
//   NUM_STAGES  chained elastic stages, legal range 1..4
//   CNT_WIDTH   derived width of occupancy
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over flush and handshakes)
//   flush      synchronous kill of all held entries
//   in_valid   upstream entry present
//   in_ready   block accepts an entry this cycle
//   in_ctrl    upstream control bits
//   in_data    upstream payload
//   out_valid  head entry presented downstream
//   out_ready  downstream accepts this cycle
//   out_ctrl   head control bits, zero when out_valid is low
//   out_data   head payload (not gated)
//   occupancy  number of valid entries held, 0..2*NUM_STAGES
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
  parameter  int DATA_WIDTH = 64,
  parameter  int CTRL_WIDTH = 2,
  parameter  int NUM_STAGES = 1,
  localparam int CNT_WIDTH  = $clog2(2*NUM_STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  // Per-stage main and skid registers.
  logic [NUM_STAGES-1:0]                 r_m_valid;
  logic [NUM_STAGES-1:0][CTRL_WIDTH-1:0] r_m_ctrl;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] r_m_data;
  logic [NUM_STAGES-1:0]                 r_s_valid;
  logic [NUM_STAGES-1:0][CTRL_WIDTH-1:0] r_s_ctrl;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] r_s_data;
  logic [CNT_WIDTH-1:0]                  r_occ;

  // Per-stage view of the upstream link and the downstream ready.
  logic [NUM_STAGES-1:0]                 w_up_valid;
  logic [NUM_STAGES-1:0][CTRL_WIDTH-1:0] w_up_ctrl;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] w_up_data;
  logic [NUM_STAGES-1:0]                 w_dn_ready;
  logic [NUM_STAGES-1:0]                 w_push;
  logic [NUM_STAGES-1:0]                 w_pop;
  logic                                  w_in_fire;
  logic                                  w_out_fire;

  for (genvar gs = 0; gs < NUM_STAGES; gs++) begin : g_link
    if (gs == 0) begin : g_first
      assign w_up_valid[gs] = in_valid;
      assign w_up_ctrl[gs]  = in_ctrl;
      assign w_up_data[gs]  = in_data;
    end else begin : g_chain
      assign w_up_valid[gs] = r_m_valid[gs-1];
      assign w_up_ctrl[gs]  = r_m_ctrl[gs-1];
      assign w_up_data[gs]  = r_m_data[gs-1];
    end

    // A stage is ready whenever its skid is empty; this is a pure register
    // output, so ready never ripples combinationally back along the chain.
    if (gs == NUM_STAGES-1) begin : g_last
      assign w_dn_ready[gs] = out_ready;
    end else begin : g_inner
      assign w_dn_ready[gs] = ~r_s_valid[gs+1];
    end

    assign w_push[gs] = w_up_valid[gs] & ~r_s_valid[gs];
    assign w_pop[gs]  = r_m_valid[gs] & w_dn_ready[gs];
  end

  // Flush only gates the boundary handshakes; the last stage's pop is harmless
  // during flush because every valid bit clears at that edge anyway.
  assign in_ready   = ~r_s_valid[0] & ~flush;
  assign out_valid  = r_m_valid[NUM_STAGES-1] & ~flush;
  assign out_ctrl   = r_m_ctrl[NUM_STAGES-1] & {CTRL_WIDTH{out_valid}};
  assign out_data   = r_m_data[NUM_STAGES-1];
  assign occupancy  = r_occ;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload registers are reset here because out_data is
      // ungated and must read zero after reset; a plain storage array with no
      // observable reset value would normally be left out of the reset branch.
      r_m_valid <= '0;
      r_m_ctrl  <= '0;
      r_m_data  <= '0;
      r_s_valid <= '0;
      r_s_ctrl  <= '0;
      r_s_data  <= '0;
      r_occ     <= '0;
    end else if (flush) begin
      // Payload and ctrl hold their values; out_ctrl is masked by out_valid.
      r_m_valid <= '0;
      r_s_valid <= '0;
      r_occ     <= '0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (!r_m_valid[s] || w_pop[s]) begin
          // Main is free this cycle: refill from skid first to keep FIFO order.
          // A push cannot coincide with a full skid since ready was low.
          if (r_s_valid[s]) begin
            r_m_valid[s] <= 1'b1;
            r_m_ctrl[s]  <= r_s_ctrl[s];
            r_m_data[s]  <= r_s_data[s];
            r_s_valid[s] <= 1'b0;
          end else if (w_push[s]) begin
            r_m_valid[s] <= 1'b1;
            r_m_ctrl[s]  <= w_up_ctrl[s];
            r_m_data[s]  <= w_up_data[s];
          end else begin
            r_m_valid[s] <= 1'b0;
          end
        end else if (w_push[s]) begin
          // Main is stalled: park the incoming entry in the (empty) skid.
          r_s_valid[s] <= 1'b1;
          r_s_ctrl[s]  <= w_up_ctrl[s];
          r_s_data[s]  <= w_up_data[s];
        end
      end
      // Internal stage-to-stage moves do not change the total count.
      r_occ <= r_occ + CNT_WIDTH'(w_in_fire) - CNT_WIDTH'(w_out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Drives four instances of pipe_stage_elastic (NUM_STAGES = 1..4) from one
// shared set of inputs. Each instance has its own outputs and its own
// reference queue. Inputs change on the falling edge and outputs are sampled
// 1 time unit later, so every expected value describes the cycle in which
// those inputs are applied.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_ready;

  logic        ir    [NI];
  logic        ov    [NI];
  logic [1:0]  oc    [NI];
  logic [63:0] od    [NI];
  logic [3:0]  occ_a [NI];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(2*(g+1)+1)-1:0] occ_l;
    assign occ_a[g] = 4'(occ_l);

    pipe_stage_elastic #(
      .DATA_WIDTH (64),
      .CTRL_WIDTH (2),
      .NUM_STAGES (g+1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_ctrl  (oc[g]),
      .out_data  (od[g]),
      .occupancy (occ_l)
    );
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and let them settle.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [1:0] c, input logic [63:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Holds rst for exactly one rising edge; the next cyc() releases it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [1:0]  ctrl;
    logic [63:0] data;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_oc;
    logic [63:0] e_od;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t tbl [16];

  // Reference queues for the random phase: {ctrl, data} per accepted entry.
  logic [65:0] mq [NI][$];
  int          delivered [NI];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nout;
    int nval;
    int bias;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    // ---------------- table: NUM_STAGES = 1 (instance 0) ----------------
    //                rst   flush iv    ctrl  data    ordy   ir    ov    oc    od      occ
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  1'b1,  1'b1, 1'b0, 2'd0, 64'h0,  4'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'd3, 64'hA5, 1'b1,  1'b1, 1'b0, 2'd0, 64'h0,  4'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  1'b1,  1'b1, 1'b1, 2'd3, 64'hA5, 4'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  1'b1,  1'b1, 1'b0, 2'd0, 64'hA5, 4'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 64'h10, 1'b0,  1'b1, 1'b0, 2'd0, 64'hA5, 4'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd2, 64'h11, 1'b0,  1'b1, 1'b1, 2'd1, 64'h10, 4'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 64'h12, 1'b0,  1'b0, 1'b1, 2'd1, 64'h10, 4'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 64'h12, 1'b1,  1'b0, 1'b1, 2'd1, 64'h10, 4'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd3, 64'h12, 1'b1,  1'b1, 1'b1, 2'd2, 64'h11, 4'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  1'b0,  1'b1, 1'b1, 2'd3, 64'h12, 4'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd1, 64'h13, 1'b1,  1'b0, 1'b0, 2'd0, 64'h12, 4'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  1'b1,  1'b1, 1'b0, 2'd0, 64'h12, 4'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd2, 64'h20, 1'b0,  1'b1, 1'b0, 2'd0, 64'h12, 4'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 64'h21, 1'b0,  1'b1, 1'b1, 2'd2, 64'h20, 4'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h0,  1'b0,  1'b0, 1'b1, 2'd2, 64'h20, 4'd2};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,  1'b0,  1'b1, 1'b0, 2'd0, 64'h0,  4'd0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ctrl, tbl[i].data, tbl[i].ordy);
      check($sformatf("tbl%0d_in_ready", i),  66'(ir[0]),    66'(tbl[i].e_ir));
      check($sformatf("tbl%0d_out_valid", i), 66'(ov[0]),    66'(tbl[i].e_ov));
      check($sformatf("tbl%0d_out_ctrl", i),  66'(oc[0]),    66'(tbl[i].e_oc));
      check($sformatf("tbl%0d_out_data", i),  66'(od[0]),    66'(tbl[i].e_od));
      check($sformatf("tbl%0d_occupancy", i), 66'(occ_a[0]), 66'(tbl[i].e_occ));
    end

    // ---------------- NUM_STAGES = 3: 16-entry stream (instance 2) ----------------
    do_reset();
    for (int c = 0; c < 21; c++) begin
      cyc(1'b0, 1'b0, c < 16, 2'b01, 64'(c), 1'b1);
      check($sformatf("stream_c%0d_valid", c), 66'(ov[2]), 66'(c >= 3 && c < 19));
      check($sformatf("stream_c%0d_ready", c), 66'(ir[2]), 66'd1);
      if (c >= 3 && c < 19) check($sformatf("stream_c%0d_data", c), 66'(od[2]), 66'(c - 3));
    end

    // ---------------- NUM_STAGES = 2: fill under backpressure, then drain ----------------
    do_reset();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 64'(k), 1'b0);
      if (ir[1]) k++;
    end
    cyc(1'b0, 1'b0, 1'b1, 2'b10, 64'(k), 1'b0);
    check("fill_accepted", 66'(k), 66'd4);
    check("fill_in_ready", 66'(ir[1]), 66'd0);
    check("fill_occupancy", 66'(occ_a[1]), 66'd4);
    nout = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 64'(k), 1'b1);
      if (ov[1]) begin
        check($sformatf("drain_out%0d", nout), {oc[1], od[1]}, {2'b10, 64'(nout)});
        nout++;
      end
      if (ir[1]) k++;
    end
    check("drain_count", 66'(nout), 66'd16);

    // ---------------- NUM_STAGES = 2: flush with occupancy 3 ----------------
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 1'b1, 2'b11, 64'h40 + 64'(c), 1'b0);
      check($sformatf("pre_flush_ready%0d", c), 66'(ir[1]), 66'd1);
    end
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 64'h50, 1'b1);
    check("flush_occ_before", 66'(occ_a[1]), 66'd3);
    check("flush_in_ready",   66'(ir[1]),    66'd0);
    check("flush_out_valid",  66'(ov[1]),    66'd0);
    check("flush_out_ctrl",   66'(oc[1]),    66'd0);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 1'b1);
    check("post_flush_occ",   66'(occ_a[1]), 66'd0);
    check("post_flush_ctrl",  66'(oc[1]),    66'd0);
    check("post_flush_valid", 66'(ov[1]),    66'd0);
    cyc(1'b0, 1'b0, 1'b1, 2'b01, 64'h60, 1'b1);
    nval = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 1'b1);
      if (ov[1]) begin
        check("post_flush_entry", {oc[1], od[1]}, {2'b01, 64'h60});
        nval++;
      end
    end
    check("post_flush_count", 66'(nval), 66'd1);

    // ---------------- random traffic against reference queues ----------------
    do_reset();
    for (int g = 0; g < NI; g++) begin
      mq[g].delete();
      delivered[g] = 0;
    end
    bias = 5;
    for (int c = 0; c < 10000; c++) begin
      if (c % 256 == 0) bias = $urandom_range(1, 9);
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 3) != 0, 2'($urandom), {$urandom, $urandom},
          $urandom_range(0, 9) < bias);
      for (int g = 0; g < NI; g++) begin
        if (!ov[g]) check($sformatf("rand_c%0d_i%0d_ctrl_gate", c, g), 66'(oc[g]), 66'd0);
        if (mq[g].size() == 0) check($sformatf("rand_c%0d_i%0d_spurious", c, g), 66'(ov[g]), 66'd0);
        else if (ov[g]) check($sformatf("rand_c%0d_i%0d_head", c, g), {oc[g], od[g]}, mq[g][0]);
        check($sformatf("rand_c%0d_i%0d_occ", c, g), 66'(occ_a[g]), 66'(mq[g].size()));
        if (flush) begin
          check($sformatf("rand_c%0d_i%0d_flush_ready", c, g), 66'(ir[g]), 66'd0);
          check($sformatf("rand_c%0d_i%0d_flush_valid", c, g), 66'(ov[g]), 66'd0);
        end else if (mq[g].size() == 0) begin
          check($sformatf("rand_c%0d_i%0d_empty_ready", c, g), 66'(ir[g]), 66'd1);
        end
        if (mq[g].size() == 2*(g+1))
          check($sformatf("rand_c%0d_i%0d_full_ready", c, g), 66'(ir[g]), 66'd0);

        // Advance the reference across the coming rising edge.
        if (rst || flush) begin
          mq[g].delete();
        end else begin
          if (ov[g] && out_ready) begin
            void'(mq[g].pop_front());
            delivered[g]++;
          end
          if (in_valid && ir[g]) mq[g].push_back({in_ctrl, in_data});
        end
      end
    end
    for (int g = 0; g < NI; g++)
      check($sformatf("rand_i%0d_progress", g), 66'(delivered[g] > 1000), 66'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
